// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
//   Hazard and stall controller for the 5-stage ARM pipeline. It runs beside the
//   forwarding unit. It holds PC and IF/ID and inserts an ID/EXE bubble on RAW
//   hazards. It freezes the whole pipe while a slow SRAM access is outstanding
//   and flushes IF/ID on a taken branch. It also keeps saturating stall/freeze
//   counters and a sticky memory-timeout flag.
//
// Ports
//   clk            core clock
//   rst            synchronous active-low reset; gates every output to 0 while low
//   forward_en     forwarding unit active (only load-use is then a hazard)
//   id_valid       ID stage holds a real instruction
//   two_src        ID instruction reads src2
//   src1, src2     ID source register numbers
//   exe_wb_en      EXE write-back enable
//   exe_mem_r_en   EXE instruction is a load
//   exe_dest       EXE destination register
//   mem_wb_en      MEM write-back enable
//   mem_dest       MEM destination register
//   mem_req        MEM stage issues an SRAM access this cycle
//   mem_ready      SRAM access complete
//   branch_taken   taken branch resolved in EXE
//   clr_cnt        clear both counters and the timeout flag
//   hazard_stall   hold PC and IF/ID (same cycle)
//   bubble         load a NOP into ID/EXE (same cycle)
//   flush          squash IF/ID (same cycle)
//   freeze_all     hold every pipeline register (same cycle)
//   mem_timeout    sticky SRAM timeout flag
//   stall_cnt      saturating count of hazard_stall cycles
//   freeze_cnt     saturating count of freeze_all cycles
module hazard_stall_ctrl #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             forward_en,
  input  logic             id_valid,
  input  logic             two_src,
  input  logic [3:0]       src1,
  input  logic [3:0]       src2,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [3:0]       exe_dest,
  input  logic             mem_wb_en,
  input  logic [3:0]       mem_dest,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             branch_taken,
  input  logic             clr_cnt,
  output logic             hazard_stall,
  output logic             bubble,
  output logic             flush,
  output logic             freeze_all,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] freeze_cnt
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [WAIT_W-1:0] wait_inc;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  freeze_cnt_q, freeze_cnt_d;
  logic              mem_timeout_q, mem_timeout_d;
  logic              timeout_set;

  logic match1, match2, mmatch1, mmatch2;
  logic raw_hz;

  logic hazard_stall_c, bubble_c, flush_c, freeze_all_c;

  // Source/destination comparisons; r0 and r15 are ordinary registers here.
  always_comb begin
    match1  = (src1 == exe_dest);
    match2  = two_src & (src2 == exe_dest);
    mmatch1 = (src1 == mem_dest);
    mmatch2 = two_src & (src2 == mem_dest);
  end

  // With forwarding only a load in EXE cannot be bypassed; without it any
  // pending write in EXE or MEM blocks the ID instruction.
  always_comb begin
    if (forward_en) begin
      raw_hz = id_valid & exe_wb_en & exe_mem_r_en & (match1 | match2);
    end else begin
      raw_hz = id_valid & ((exe_wb_en & (match1 | match2)) |
                           (mem_wb_en & (mmatch1 | mmatch2)));
    end
  end

  // State, wait counter, perf counters and timeout flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= RUN;
      wait_q        <= '0;
      stall_cnt_q   <= '0;
      freeze_cnt_q  <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      stall_cnt_q   <= stall_cnt_d;
      freeze_cnt_q  <= freeze_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  // Next-state and Mealy outputs.
  // wait_q counts the cycles of the access so far (the RUN cycle that started
  // it counts as 1). The access is abandoned on the cycle that would make the
  // count reach MEM_TIMEOUT, so MEM_TIMEOUT-1 cycles in total are frozen.
  always_comb begin
    state_d        = state_q;
    wait_d         = wait_q;
    wait_inc       = wait_q + WAIT_ONE;
    timeout_set    = 1'b0;
    hazard_stall_c = 1'b0;
    bubble_c       = 1'b0;
    flush_c        = 1'b0;
    freeze_all_c   = 1'b0;

    case (state_q)
      RUN: begin
        if (mem_req && !mem_ready) begin
          freeze_all_c = 1'b1;
          state_d      = MEM_WAIT;
          wait_d       = WAIT_ONE;
        end else if (branch_taken) begin
          // The ID instruction is squashed, so its hazard does not matter.
          flush_c = 1'b1;
        end else if (raw_hz) begin
          hazard_stall_c = 1'b1;
          bubble_c       = 1'b1;
        end
      end

      MEM_WAIT: begin
        if (mem_ready) begin
          state_d = RUN;
          wait_d  = '0;
          if (branch_taken) begin
            flush_c = 1'b1;
          end else if (raw_hz) begin
            hazard_stall_c = 1'b1;
            bubble_c       = 1'b1;
          end
        end else if (wait_inc == WAIT_LAST) begin
          timeout_set = 1'b1;
          state_d     = RUN;
          wait_d      = '0;
        end else begin
          freeze_all_c = 1'b1;
          wait_d       = wait_inc;
        end
      end

      default: begin
        state_d = RUN;
        wait_d  = '0;
      end
    endcase
  end

  // Saturating counters; a clear wins over a same-edge increment.
  always_comb begin
    stall_cnt_d   = stall_cnt_q;
    freeze_cnt_d  = freeze_cnt_q;
    mem_timeout_d = mem_timeout_q | timeout_set;
    if (clr_cnt) begin
      stall_cnt_d   = '0;
      freeze_cnt_d  = '0;
      mem_timeout_d = 1'b0;
    end else begin
      if (hazard_stall_c && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (freeze_all_c && (freeze_cnt_q != '1)) begin
        freeze_cnt_d = freeze_cnt_q + CNT_W'(1);
      end
    end
  end

  // Everything reads as 0 while reset is held, even before the reset edge.
  assign hazard_stall = rst & hazard_stall_c;
  assign bubble       = rst & bubble_c;
  assign flush        = rst & flush_c;
  assign freeze_all   = rst & freeze_all_c;
  assign mem_timeout  = rst & mem_timeout_q;
  assign stall_cnt    = rst ? stall_cnt_q  : '0;
  assign freeze_cnt   = rst ? freeze_cnt_q : '0;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;

  logic       clk;
  logic       rst;
  logic       forward_en, id_valid, two_src;
  logic [3:0] src1, src2, exe_dest, mem_dest;
  logic       exe_wb_en, exe_mem_r_en, mem_wb_en;
  logic       mem_req, mem_ready, branch_taken, clr_cnt;

  logic        hazard_stall, bubble, flush, freeze_all, mem_timeout;
  logic [15:0] stall_cnt, freeze_cnt;

  logic       to_hazard_stall, to_bubble, to_flush, to_freeze_all, to_mem_timeout;
  logic [1:0] to_stall_cnt, to_freeze_cnt;

  int checks   = 0;
  int failures = 0;

  hazard_stall_ctrl #(.CNT_W(16), .MEM_TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .forward_en(forward_en), .id_valid(id_valid),
    .two_src(two_src), .src1(src1), .src2(src2), .exe_wb_en(exe_wb_en),
    .exe_mem_r_en(exe_mem_r_en), .exe_dest(exe_dest), .mem_wb_en(mem_wb_en),
    .mem_dest(mem_dest), .mem_req(mem_req), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .clr_cnt(clr_cnt),
    .hazard_stall(hazard_stall), .bubble(bubble), .flush(flush),
    .freeze_all(freeze_all), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .freeze_cnt(freeze_cnt)
  );

  // Short-timeout, 2-bit-counter instance for timeout and saturation cases.
  hazard_stall_ctrl #(.CNT_W(2), .MEM_TIMEOUT(4)) dut_to (
    .clk(clk), .rst(rst), .forward_en(forward_en), .id_valid(id_valid),
    .two_src(two_src), .src1(src1), .src2(src2), .exe_wb_en(exe_wb_en),
    .exe_mem_r_en(exe_mem_r_en), .exe_dest(exe_dest), .mem_wb_en(mem_wb_en),
    .mem_dest(mem_dest), .mem_req(mem_req), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .clr_cnt(clr_cnt),
    .hazard_stall(to_hazard_stall), .bubble(to_bubble), .flush(to_flush),
    .freeze_all(to_freeze_all), .mem_timeout(to_mem_timeout),
    .stall_cnt(to_stall_cnt), .freeze_cnt(to_freeze_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    forward_en   = 1'b0; id_valid  = 1'b0; two_src   = 1'b0;
    src1         = 4'd0; src2      = 4'd0; exe_dest  = 4'd0; mem_dest = 4'd0;
    exe_wb_en    = 1'b0; exe_mem_r_en = 1'b0; mem_wb_en = 1'b0;
    mem_req      = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0;
  endtask

  initial begin
    idle();
    clr_cnt = 1'b0;
    rst     = 1'b0;

    // Outputs are forced low while reset is held, even before any edge.
    #3;
    chk("rst_hs",     32'(hazard_stall), 32'd0);
    chk("rst_frz",    32'(freeze_all),   32'd0);
    chk("rst_flush",  32'(flush),        32'd0);
    chk("rst_to",     32'(mem_timeout),  32'd0);
    chk("rst_scnt",   32'(stall_cnt),    32'd0);
    cyc(); cyc();
    rst = 1'b1;
    #4;
    chk("rst_scnt_q", 32'(stall_cnt),  32'd0);
    chk("rst_fcnt_q", 32'(freeze_cnt), 32'd0);
    chk("rst_to_q",   32'(mem_timeout), 32'd0);
    cyc();

    // Load-use with forwarding: one stall cycle.
    forward_en = 1'b1; id_valid = 1'b1; src1 = 4'd3;
    exe_dest = 4'd3; exe_wb_en = 1'b1; exe_mem_r_en = 1'b1;
    #4;
    chk("lu_hs",    32'(hazard_stall), 32'd1);
    chk("lu_bub",   32'(bubble),       32'd1);
    chk("lu_flush", 32'(flush),        32'd0);
    chk("lu_frz",   32'(freeze_all),   32'd0);
    cyc();
    exe_wb_en = 1'b0; exe_mem_r_en = 1'b0; src1 = 4'd4;
    #4;
    chk("lu_after_hs", 32'(hazard_stall), 32'd0);
    chk("lu_scnt",     32'(stall_cnt),    32'd1);
    cyc();

    // ALU producer: forwarded, then not forwarded.
    exe_wb_en = 1'b1; exe_mem_r_en = 1'b0; exe_dest = 4'd3; src1 = 4'd3;
    #4;
    chk("add_fwd_hs", 32'(hazard_stall), 32'd0);
    cyc();
    forward_en = 1'b0;
    #4;
    chk("add_nofwd_hs",  32'(hazard_stall), 32'd1);
    chk("add_nofwd_bub", 32'(bubble),       32'd1);
    cyc();
    exe_dest = 4'd7; src1 = 4'd1; src2 = 4'd5; two_src = 1'b1;
    mem_wb_en = 1'b1; mem_dest = 4'd5;
    #4;
    chk("mem_src2_hs", 32'(hazard_stall), 32'd1);
    cyc();
    two_src = 1'b0;
    #4;
    chk("mem_src2_off_hs", 32'(hazard_stall), 32'd0);
    chk("scnt3",           32'(stall_cnt),    32'd3);
    chk("to_scnt3",        32'(to_stall_cnt), 32'd3);
    cyc();
    src1 = 4'd7;
    #4;
    chk("exe_src1_hs", 32'(hazard_stall), 32'd1);
    cyc();
    idle();
    #4;
    chk("scnt4",        32'(stall_cnt),    32'd4);
    chk("to_scnt_sat",  32'(to_stall_cnt), 32'd3);
    cyc();

    // Slow SRAM: ready low for 5 cycles, then high.
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #4;
      chk("slow_frz", 32'(freeze_all), 32'd1);
      cyc();
    end
    mem_ready = 1'b1;
    #4;
    chk("slow_ready_frz", 32'(freeze_all), 32'd0);
    cyc();
    mem_req = 1'b0; mem_ready = 1'b0; branch_taken = 1'b1;
    #4;
    chk("slow_run_flush", 32'(flush),      32'd1);
    chk("slow_run_frz",   32'(freeze_all), 32'd0);
    chk("slow_fcnt",      32'(freeze_cnt), 32'd5);
    chk("to_timeout_set", 32'(to_mem_timeout), 32'd1);
    cyc();

    // Branch beats load-use; a pending SRAM freeze beats both.
    idle();
    forward_en = 1'b1; id_valid = 1'b1; src1 = 4'd3;
    exe_dest = 4'd3; exe_wb_en = 1'b1; exe_mem_r_en = 1'b1; branch_taken = 1'b1;
    #4;
    chk("br_flush", 32'(flush),        32'd1);
    chk("br_hs",    32'(hazard_stall), 32'd0);
    chk("br_bub",   32'(bubble),       32'd0);
    cyc();
    mem_req = 1'b1; mem_ready = 1'b0;
    #4;
    chk("brfrz_frz",   32'(freeze_all),   32'd1);
    chk("brfrz_flush", 32'(flush),        32'd0);
    chk("brfrz_hs",    32'(hazard_stall), 32'd0);
    cyc();
    mem_ready = 1'b1;
    #4;
    chk("brrdy_frz",   32'(freeze_all),   32'd0);
    chk("brrdy_flush", 32'(flush),        32'd1);
    chk("brrdy_hs",    32'(hazard_stall), 32'd0);
    cyc();

    // Clear overrides a same-edge stall increment.
    idle();
    clr_cnt = 1'b1; id_valid = 1'b1; src1 = 4'd2; exe_dest = 4'd2; exe_wb_en = 1'b1;
    #4;
    chk("clr_hs",     32'(hazard_stall), 32'd1);
    chk("pre_clr_sc", 32'(stall_cnt),    32'd4);
    cyc();
    idle();
    clr_cnt = 1'b0;
    #4;
    chk("clr_scnt",  32'(stall_cnt),      32'd0);
    chk("clr_fcnt",  32'(freeze_cnt),     32'd0);
    chk("clr_to",    32'(to_mem_timeout), 32'd0);
    chk("clr_tofc",  32'(to_freeze_cnt),  32'd0);
    cyc();

    // Timeout with MEM_TIMEOUT=4: 3 frozen cycles, released on the 4th.
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #4;
      chk("tmo_frz", 32'(to_freeze_all), 32'd1);
      cyc();
    end
    #4;
    chk("tmo_rel_frz", 32'(to_freeze_all), 32'd0);
    chk("tmo_rel_fl",  32'(to_flush),      32'd0);
    chk("long_frz",    32'(freeze_all),    32'd1);
    cyc();
    mem_req = 1'b0; mem_ready = 1'b1;
    #4;
    chk("tmo_flag",  32'(to_mem_timeout), 32'd1);
    chk("tmo_fcnt",  32'(to_freeze_cnt),  32'd3);
    chk("tmo_frz0",  32'(to_freeze_all),  32'd0);
    cyc();
    idle();
    #4;
    chk("tmo_sticky", 32'(to_mem_timeout), 32'd1);
    chk("long_noto",  32'(mem_timeout),    32'd0);
    cyc();
    clr_cnt = 1'b1;
    cyc();
    clr_cnt = 1'b0;
    #4;
    chk("tmo_clr",      32'(to_mem_timeout), 32'd0);
    chk("tmo_clr_fcnt", 32'(to_freeze_cnt),  32'd0);
    cyc();

    // Reset while in MEM_WAIT.
    mem_req = 1'b1; mem_ready = 1'b0;
    #4;
    chk("rmw_frz0", 32'(freeze_all), 32'd1);
    cyc();
    #4;
    chk("rmw_frz1", 32'(freeze_all), 32'd1);
    chk("rmw_fcnt", 32'(freeze_cnt), 32'd1);
    cyc();
    rst = 1'b0;
    #4;
    chk("rmw_rst_frz",    32'(freeze_all),    32'd0);
    chk("rmw_rst_to_frz", 32'(to_freeze_all), 32'd0);
    cyc();
    rst = 1'b1;
    idle();
    #4;
    chk("rmw_after_fcnt", 32'(freeze_cnt), 32'd0);
    chk("rmw_after_scnt", 32'(stall_cnt),  32'd0);
    chk("rmw_after_frz",  32'(freeze_all), 32'd0);
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
